// File: rtl/nios_system_oci_trace_packer.sv
// OCI trace packer: packs SLOT_W-bit trace slots into SLOTS-slot words, queues them
// in a DEPTH-entry FIFO drained over valid/ready, and runs an end-of-test flush/drain.
module nios_system_oci_trace_packer #(
  parameter int SLOT_W = 2,
  parameter int SLOTS  = 15,
  parameter int DEPTH  = 4,
  parameter int BUF_W  = SLOTS * SLOT_W,
  parameter int CNT_W  = $clog2(SLOTS + 1),
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [SLOT_W-1:0] in_data,
  input  logic              test_ending,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BUF_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  output logic [7:0]        drop_cnt,
  output logic              test_has_ended
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = BUF_W + CNT_W;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_DRAIN = 2'd2,
    S_ENDED = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [BUF_W-1:0]   r_buf;
  logic [CNT_W-1:0]   r_count;
  logic [ENT_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_out_valid;
  logic [BUF_W-1:0]   r_out_data;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_overflow;
  logic [7:0]         r_drop_cnt;
  logic               r_ended;

  logic               w_pop;
  logic               w_full;
  logic               w_can_push;
  logic [BUF_W-1:0]   w_shift;
  logic               w_run_slot;
  logic               w_word_done;
  logic               w_flush_req;
  logic               w_push;
  logic               w_drop;
  logic               w_clear;
  logic [ENT_W-1:0]   w_push_entry;
  logic [LVL_W-1:0]   w_avail;
  logic [PTR_W-1:0]   w_rd_next;
  logic [ENT_W-1:0]   w_head;

  always_comb begin
    w_pop      = r_out_valid & out_ready;
    w_full     = (r_level == LVL_W'(DEPTH));
    w_can_push = ~w_full | w_pop;
    w_shift    = (r_buf << SLOT_W) | BUF_W'(in_data);
    // Entries that survive this edge's pop; a word pushed now becomes visible one edge later.
    w_avail    = r_level - LVL_W'(w_pop);
    w_rd_next  = r_rd_ptr + PTR_W'(w_pop);
    w_head     = r_mem[w_rd_next];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN: begin
        w_state_next = test_ending ? S_FLUSH : S_RUN;
      end
      S_FLUSH: begin
        if (r_count == CNT_W'(0)) begin
          w_state_next = S_DRAIN;
        end else if (w_can_push) begin
          w_state_next = S_DRAIN;
        end else begin
          w_state_next = S_FLUSH;
        end
      end
      S_DRAIN: begin
        w_state_next = (r_level == LVL_W'(0)) ? S_ENDED : S_DRAIN;
      end
      S_ENDED: begin
        w_state_next = S_ENDED;
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase
  end

  always_comb begin
    w_run_slot  = 1'b0;
    w_word_done = 1'b0;
    w_flush_req = 1'b0;
    case (r_state)
      S_RUN: begin
        w_run_slot  = in_valid;
        w_word_done = in_valid & (r_count == CNT_W'(SLOTS - 1));
      end
      S_FLUSH: begin
        w_flush_req = (r_count != CNT_W'(0));
      end
      default: begin
        w_run_slot  = 1'b0;
      end
    endcase
    // A flush push stalls rather than drops; a completed word in RUN drops when blocked.
    w_push       = (w_word_done | w_flush_req) & w_can_push;
    w_drop       = w_word_done & ~w_can_push;
    w_clear      = w_word_done | (w_flush_req & w_can_push);
    w_push_entry = w_word_done ? {w_shift, CNT_W'(SLOTS)} : {r_buf, r_count};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf   <= '0;
      r_count <= '0;
    end else if (w_clear) begin
      r_buf   <= '0;
      r_count <= '0;
    end else if (w_run_slot) begin
      r_buf   <= w_shift;
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_buf   <= r_buf;
      r_count <= r_count;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
      r_rd_ptr <= w_rd_next;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else if (w_avail != LVL_W'(0)) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_head[ENT_W-1:CNT_W];
      r_out_count <= w_head[CNT_W-1:0];
    end else begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
      r_ended    <= 1'b0;
    end else begin
      r_overflow <= r_overflow | w_drop;
      if (w_drop && (r_drop_cnt != 8'd255)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end else begin
        r_drop_cnt <= r_drop_cnt;
      end
      r_ended <= (w_state_next == S_ENDED);
    end
  end

  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_count      = r_out_count;
  assign fifo_level     = r_level;
  assign overflow       = r_overflow;
  assign drop_cnt       = r_drop_cnt;
  assign test_has_ended = r_ended;

endmodule

// File: tb/tb_nios_system_oci_trace_packer.sv
// Randomized bench for the trace packer, checked against a slot/word queue model.
module tb_nios_system_oci_trace_packer;
  localparam int SLOT_W = 2;
  localparam int SLOTS  = 15;
  localparam int DEPTH  = 4;
  localparam int BUF_W  = 30;
  localparam int CNT_W  = 4;
  localparam int LVL_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [SLOT_W-1:0] in_data;
  logic              test_ending;
  logic              out_valid;
  logic              out_ready;
  logic [BUF_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic              test_has_ended;

  logic              b_in_valid;
  logic [3:0]        b_in_data;
  logic              b_test_ending;
  logic              b_out_valid;
  logic              b_out_ready;
  logic [31:0]       b_out_data;
  logic [3:0]        b_out_count;
  logic [2:0]        b_fifo_level;
  logic              b_overflow;
  logic [7:0]        b_drop_cnt;
  logic              b_ended;

  int errors = 0;
  int checks = 0;

  nios_system_oci_trace_packer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .test_ending(test_ending), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .fifo_level(fifo_level),
    .overflow(overflow), .drop_cnt(drop_cnt), .test_has_ended(test_has_ended)
  );

  nios_system_oci_trace_packer #(.SLOT_W(4), .SLOTS(8), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data(b_in_data),
    .test_ending(b_test_ending), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_count(b_out_count), .fifo_level(b_fifo_level),
    .overflow(b_overflow), .drop_cnt(b_drop_cnt), .test_has_ended(b_ended)
  );

  always #5 clk = ~clk;

  // Reference model: queued words stamped with their push edge, slots as a list.
  typedef struct {
    logic [BUF_W-1:0] d;
    int               c;
    int               t;
  } word_t;

  word_t            q[$];
  int               slots[$];
  int               mstate;   // 0 run, 1 flush, 2 drain, 3 ended
  int               edge_n;
  bit               m_valid;
  logic [BUF_W-1:0] m_data;
  int               m_count;
  int               m_level;
  bit               m_ovf;
  int               m_drop;
  bit               m_ended;

  task automatic model_reset();
    q.delete();
    slots.delete();
    mstate  = 0;
    m_valid = 0;
    m_data  = '0;
    m_count = 0;
    m_level = 0;
    m_ovf   = 0;
    m_drop  = 0;
    m_ended = 0;
  endtask

  task automatic emit(input bit can, input int e);
    word_t w;
    w.d = '0;
    foreach (slots[i]) w.d = (w.d << SLOT_W) | BUF_W'(slots[i]);
    w.c = slots.size();
    w.t = e;
    if (can) begin
      q.push_back(w);
    end else begin
      m_ovf = 1;
      if (m_drop < 255) m_drop++;
    end
    slots.delete();
  endtask

  task automatic model_edge();
    int lvl0;
    int e;
    bit pop;
    bit can;
    e = edge_n;
    edge_n++;
    lvl0 = q.size();
    pop  = m_valid && (out_ready === 1'b1);
    can  = (lvl0 < DEPTH) || pop;
    if (pop) q.delete(0);
    case (mstate)
      0: begin
        if (in_valid) begin
          slots.push_back(int'(in_data));
          if (slots.size() == SLOTS) emit(can, e);
        end
        if (test_ending) mstate = 1;
      end
      1: begin
        if (slots.size() == 0) mstate = 2;
        else if (can) begin
          emit(1'b1, e);
          mstate = 2;
        end
      end
      2: if (lvl0 == 0) mstate = 3;
      default: ;
    endcase
    m_valid = (q.size() != 0) && (q[0].t < e);
    m_data  = m_valid ? q[0].d : '0;
    m_count = m_valid ? q[0].c : 0;
    m_level = q.size();
    m_ended = (mstate == 3);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    test_ending = 1'b0;
    out_ready = 1'b0;
    b_in_valid = 1'b0;
    b_in_data = '0;
    b_test_ending = 1'b0;
    b_out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({out_valid, out_data, out_count, fifo_level, overflow, drop_cnt, test_has_ended} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h c=%0d l=%0d o=%b dc=%0d e=%b, want all zero",
               out_valid, out_data, out_count, fifo_level, overflow, drop_cnt, test_has_ended);
    end
  endtask

  task automatic test_single_word();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < SLOTS; i++) begin
      in_valid = 1'b1;
      in_data = SLOT_W'((i % 3) + 1);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_valid: got %b want 0", out_valid);
    end
    step();
    checks++;
    if ({out_valid, out_data, out_count} !== {1'b1, 30'h1B6D_B6DB, 4'd15}) begin
      errors++;
      $display("FAIL single_word: got v=%b d=%h c=%0d want v=1 d=1b6db6db c=15", out_valid, out_data, out_count);
    end
    step();
    checks++;
    if ({out_valid, fifo_level} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL single_popped: got v=%b l=%0d want v=0 l=0", out_valid, fifo_level);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 5 * SLOTS; i++) begin
      in_valid = 1'b1;
      in_data = SLOT_W'($urandom_range(0, 3));
      step();
    end
    in_valid = 1'b0;
    checks++;
    if ({fifo_level, overflow, drop_cnt} !== {3'd4, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL overflow_state: got l=%0d o=%b dc=%0d want l=4 o=1 dc=1", fifo_level, overflow, drop_cnt);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if ({out_valid, fifo_level} !== {m_valid, LVL_W'(m_level)}) begin
        errors++;
        $display("FAIL ovf_drain_ctl: got v=%b l=%0d want v=%b l=%0d", out_valid, fifo_level, m_valid, m_level);
      end
      if (m_valid) begin
        checks++;
        if ({out_data, out_count} !== {m_data, CNT_W'(m_count)}) begin
          errors++;
          $display("FAIL ovf_drain_data: got d=%h c=%0d want d=%h c=%0d", out_data, out_count, m_data, m_count);
        end
      end
    end
  endtask

  task automatic test_full_accept();
    apply_reset();
    for (int i = 0; i < 5 * SLOTS; i++) begin
      in_valid = 1'b1;
      in_data = SLOT_W'($urandom_range(0, 3));
      out_ready = (i == 5 * SLOTS - 1);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({fifo_level, overflow, drop_cnt} !== {3'd4, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL full_accept: got l=%0d o=%b dc=%0d want l=4 o=0 dc=0", fifo_level, overflow, drop_cnt);
    end
  endtask

  task automatic test_flush_partial();
    int s[7];
    logic [BUF_W-1:0] exp_d;
    bit saw;
    apply_reset();
    out_ready = 1'b1;
    exp_d = '0;
    saw = 0;
    for (int i = 0; i < 7; i++) begin
      s[i] = $urandom_range(0, 3);
      exp_d = (exp_d << 2) | BUF_W'(s[i]);
      in_valid = 1'b1;
      in_data = SLOT_W'(s[i]);
      step();
    end
    in_valid = 1'b0;
    test_ending = 1'b1;
    for (int i = 0; i < 40 && test_has_ended !== 1'b1; i++) begin
      step();
      if (out_valid === 1'b1) begin
        saw = 1;
        checks++;
        if ({out_data, out_count} !== {exp_d, 4'd7}) begin
          errors++;
          $display("FAIL flush_partial_word: got d=%h c=%0d want d=%h c=7", out_data, out_count, exp_d);
        end
      end
    end
    test_ending = 1'b0;
    checks++;
    if (!saw || test_has_ended !== 1'b1 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL flush_partial_end: got saw=%0d ended=%b l=%0d want saw=1 ended=1 l=0", saw, test_has_ended, fifo_level);
    end
  endtask

  task automatic test_end_empty();
    apply_reset();
    test_ending = 1'b1;
    for (int i = 0; i < 3; i++) step();
    test_ending = 1'b0;
    checks++;
    if (test_has_ended !== 1'b1) begin
      errors++;
      $display("FAIL end_empty: got ended=%b want 1", test_has_ended);
    end
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_data = SLOT_W'($urandom_range(0, 3));
      out_ready = 1'b1;
      step();
      if (i % 10 == 9) begin
        checks++;
        if ({out_valid, fifo_level, test_has_ended} !== {1'b0, 3'd0, 1'b1}) begin
          errors++;
          $display("FAIL ended_quiet: got v=%b l=%0d e=%b want v=0 l=0 e=1", out_valid, fifo_level, test_has_ended);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_in_flush();
    apply_reset();
    for (int i = 0; i < 3 * SLOTS + 5; i++) begin
      in_valid = 1'b1;
      in_data = SLOT_W'($urandom_range(0, 3));
      step();
    end
    in_valid = 1'b0;
    test_ending = 1'b1;
    step();
    checks++;
    if (fifo_level !== 3'd3) begin
      errors++;
      $display("FAIL flush_precond: got l=%0d want 3", fifo_level);
    end
    reset = 1'b1;
    test_ending = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    checks++;
    if ({out_valid, out_data, out_count, fifo_level, overflow, drop_cnt, test_has_ended} !== '0) begin
      errors++;
      $display("FAIL reset_in_flush: got v=%b d=%h c=%0d l=%0d o=%b dc=%0d e=%b, want all zero",
               out_valid, out_data, out_count, fifo_level, overflow, drop_cnt, test_has_ended);
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    int done_at;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 9) < 8);
      in_data = SLOT_W'($urandom_range(0, 3));
      out_ready = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step();
      checks++;
      if ({out_valid, fifo_level, overflow, drop_cnt, test_has_ended} !==
          {m_valid, LVL_W'(m_level), m_ovf, 8'(m_drop), m_ended}) begin
        errors++;
        $display("FAIL rnd_ctl cyc=%0d: got v=%b l=%0d o=%b dc=%0d e=%b want v=%b l=%0d o=%b dc=%0d e=%b",
                 i, out_valid, fifo_level, overflow, drop_cnt, test_has_ended,
                 m_valid, m_level, m_ovf, m_drop, m_ended);
      end
      if (m_valid) begin
        checks++;
        if ({out_data, out_count} !== {m_data, CNT_W'(m_count)}) begin
          errors++;
          $display("FAIL rnd_data cyc=%0d: got d=%h c=%0d want d=%h c=%0d", i, out_data, out_count, m_data, m_count);
        end
      end
    end
    test_ending = 1'b1;
    done_at = -1;
    for (int i = 0; i < 200 && done_at < 0; i++) begin
      in_valid = $urandom_range(0, 1);
      in_data = SLOT_W'($urandom_range(0, 3));
      out_ready = $urandom_range(0, 1);
      step();
      checks++;
      if ({out_valid, fifo_level, test_has_ended} !== {m_valid, LVL_W'(m_level), m_ended}) begin
        errors++;
        $display("FAIL rnd_end_ctl: got v=%b l=%0d e=%b want v=%b l=%0d e=%b",
                 out_valid, fifo_level, test_has_ended, m_valid, m_level, m_ended);
      end
      if (m_valid && {out_data, out_count} !== {m_data, CNT_W'(m_count)}) begin
        errors++;
        $display("FAIL rnd_end_data: got d=%h c=%0d want d=%h c=%0d", out_data, out_count, m_data, m_count);
      end
      if (test_has_ended === 1'b1) done_at = i;
    end
    test_ending = 1'b0;
    checks++;
    if (done_at < 0) begin
      errors++;
      $display("FAIL rnd_end_timeout: got ended=%b want 1 within 200 cycles", test_has_ended);
    end
  endtask

  task automatic test_params2();
    apply_reset();
    b_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_in_valid = 1'b1;
      b_in_data = 4'((i % 3) + 1);
      step();
    end
    b_in_valid = 1'b0;
    checks++;
    if (b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL p2_early_valid: got %b want 0", b_out_valid);
    end
    step();
    checks++;
    if ({b_out_valid, b_out_data, b_out_count} !== {1'b1, 32'h1231_2312, 4'd8}) begin
      errors++;
      $display("FAIL p2_word: got v=%b d=%h c=%0d want v=1 d=12312312 c=8", b_out_valid, b_out_data, b_out_count);
    end
  endtask

  initial begin
    edge_n = 0;
    model_reset();
    test_reset();
    test_single_word();
    test_overflow();
    test_full_accept();
    test_flush_partial();
    test_end_empty();
    test_reset_in_flush();
    test_random();
    test_params2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
